// File: rtl/nios2_dbg_pkg.sv
// Shared definitions for the Nios II debug OCI memory controller:
// the JTAG-side FSM state encoding and the jdo field positions.
package nios2_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PEND_RD = 2'd1,
        ST_PEND_WR = 2'd2,
        ST_RD_CAP  = 2'd3
    } ocimem_state_e;

    localparam int JDO_W         = 38;
    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_RDEN_BIT  = 34;
    localparam int JDO_WDATA_MSB = 34;
    localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/nios2_ocimem_spram.sv
// Single-port 2**ADDR_W x 32 RAM with byte-lane write enables and a registered
// read port (data for the address presented in cycle N appears in cycle N+1).
// A write returns the old contents on o_q.
// Ports:
//   i_clk    clock
//   i_we     write enable
//   i_addr   word address
//   i_wdata  write data
//   i_be     byte-lane enables for writes
//   o_q      registered read data
module nios2_ocimem_spram #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_be,
    output logic [31:0]       o_q
);

    logic [31:0] r_mem [2**ADDR_W];
    logic [31:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
        r_q <= r_mem[i_addr];
    end

    assign o_q = r_q;

endmodule

// File: rtl/nios2_debug_ocimem_ctrl.sv
// Sysclk-side servicing of JTAG debug-memory commands against the OCI RAM,
// sharing the single-port RAM with the CPU's Avalon slave. The CPU wins
// arbitration until a pending JTAG op has lost STARVE_LIMIT cycles in a row;
// the next CPU request is then stalled with waitrequest so JTAG gets the slot.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | accepting JTAG strobes
// ST_PEND_RD | read of RAM[MonAReg] waiting for a RAM slot
// ST_PEND_WR | write of MonDReg to RAM[MonAReg] waiting for a RAM slot
// ST_RD_CAP  | RAM read issued; capture q into MonDReg on this edge
//
// Ports:
//   i_clk, i_reset_n                 clock, async active-low reset
//   i_jdo                            JTAG data-out word
//   i_take_action_ocimem_a           load address (+ optional read)
//   i_take_no_action_ocimem_a        address+1, then read
//   i_take_action_ocimem_b           write jdo data, then address+1
//   i_avs_*                          CPU Avalon slave request
//   o_avs_readdata                   CPU read data, latency 1, held between reads
//   o_avs_waitrequest                CPU stall during a forced JTAG slot
//   o_mon_dreg                       JTAG data register (MonDReg)
//   o_monitor_ready                  last JTAG op completed
//   o_monitor_error                  sticky command overrun
module nios2_debug_ocimem_ctrl
    import nios2_dbg_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [JDO_W-1:0]  i_jdo,
    input  logic              i_take_action_ocimem_a,
    input  logic              i_take_no_action_ocimem_a,
    input  logic              i_take_action_ocimem_b,
    input  logic [ADDR_W-1:0] i_avs_address,
    input  logic              i_avs_read,
    input  logic              i_avs_write,
    input  logic [31:0]       i_avs_writedata,
    input  logic [3:0]        i_avs_byteenable,
    output logic [31:0]       o_avs_readdata,
    output logic              o_avs_waitrequest,
    output logic [31:0]       o_mon_dreg,
    output logic              o_monitor_ready,
    output logic              o_monitor_error
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    ocimem_state_e     r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_mon_areg;
    logic [31:0]       r_mon_dreg;
    logic              r_ready, r_error;
    logic [SW-1:0]     r_starve_cnt;
    logic              r_cpu_rd_d;
    logic [31:0]       r_rdata_hold;

    logic w_strobe, w_cpu_acc, w_pending, w_starved, w_grant, w_forced;
    logic w_ld_addr, w_inc_addr, w_ld_wdata, w_ld_q, w_set_ready, w_clr_ready, w_set_err;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [31:0]       w_ram_wdata, w_ram_q;
    logic [3:0]        w_ram_be;
    logic              w_unused_jdo;

    assign w_unused_jdo = ^{i_jdo[JDO_W-1:JDO_RDEN_BIT+1], i_jdo[JDO_WDATA_LSB-1:0]};

    assign w_strobe  = i_take_action_ocimem_a | i_take_no_action_ocimem_a | i_take_action_ocimem_b;
    assign w_cpu_acc = i_avs_read | i_avs_write;
    assign w_pending = (r_state == ST_PEND_RD) || (r_state == ST_PEND_WR);
    assign w_starved = (r_starve_cnt == STARVE_MAX);
    assign w_grant   = w_pending && (!w_cpu_acc || w_starved);
    // A granted JTAG op with a CPU request present is a forced slot.
    assign w_forced  = w_grant && w_cpu_acc;

    assign o_avs_waitrequest = w_forced;

    assign w_ram_we    = w_grant ? (r_state == ST_PEND_WR) : i_avs_write;
    assign w_ram_addr  = w_grant ? r_mon_areg : i_avs_address;
    assign w_ram_wdata = w_grant ? r_mon_dreg : i_avs_writedata;
    assign w_ram_be    = w_grant ? 4'hF : i_avs_byteenable;

    nios2_ocimem_spram #(.ADDR_W(ADDR_W)) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .i_be    (w_ram_be),
        .o_q     (w_ram_q)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ld_addr   = 1'b0;
        w_inc_addr  = 1'b0;
        w_ld_wdata  = 1'b0;
        w_ld_q      = 1'b0;
        w_set_ready = 1'b0;
        w_clr_ready = 1'b0;
        w_set_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_take_action_ocimem_a) begin
                    w_ld_addr = 1'b1;
                    if (i_jdo[JDO_RDEN_BIT]) begin
                        w_clr_ready = 1'b1;
                        w_state_nxt = ST_PEND_RD;
                    end else begin
                        w_set_ready = 1'b1;
                    end
                end else if (i_take_no_action_ocimem_a) begin
                    w_inc_addr  = 1'b1;
                    w_clr_ready = 1'b1;
                    w_state_nxt = ST_PEND_RD;
                end else if (i_take_action_ocimem_b) begin
                    w_ld_wdata  = 1'b1;
                    w_clr_ready = 1'b1;
                    w_state_nxt = ST_PEND_WR;
                end
            end
            ST_PEND_RD: begin
                w_set_err = w_strobe;
                if (w_grant) w_state_nxt = ST_RD_CAP;
            end
            ST_PEND_WR: begin
                w_set_err = w_strobe;
                if (w_grant) begin
                    w_inc_addr  = 1'b1;
                    w_set_ready = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RD_CAP: begin
                w_set_err   = w_strobe;
                w_ld_q      = 1'b1;
                w_set_ready = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_mon_areg   <= '0;
            r_mon_dreg   <= '0;
            r_ready      <= 1'b0;
            r_error      <= 1'b0;
            r_starve_cnt <= '0;
            r_cpu_rd_d   <= 1'b0;
            r_rdata_hold <= '0;
        end else begin
            if (w_ld_addr)       r_mon_areg <= i_jdo[JDO_ADDR_LSB +: ADDR_W];
            else if (w_inc_addr) r_mon_areg <= r_mon_areg + ADDR_W'(1);

            if (w_ld_wdata)  r_mon_dreg <= i_jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
            else if (w_ld_q) r_mon_dreg <= w_ram_q;

            if (w_set_ready)      r_ready <= 1'b1;
            else if (w_clr_ready) r_ready <= 1'b0;

            if (w_set_err) r_error <= 1'b1;

            if (!w_pending || w_grant)         r_starve_cnt <= '0;
            else if (w_cpu_acc && !w_starved)  r_starve_cnt <= r_starve_cnt + SW'(1);

            // A simultaneous read+write is treated as a write only.
            r_cpu_rd_d <= i_avs_read && !i_avs_write && !w_forced;
            if (r_cpu_rd_d) r_rdata_hold <= w_ram_q;
        end
    end

    // RAM q is shared with JTAG reads, so CPU data is held separately once returned.
    assign o_avs_readdata  = r_cpu_rd_d ? w_ram_q : r_rdata_hold;
    assign o_mon_dreg      = r_mon_dreg;
    assign o_monitor_ready = r_ready;
    assign o_monitor_error = r_error;

endmodule

// File: tb/tb_nios2_debug_ocimem_ctrl.sv
module tb_nios2_debug_ocimem_ctrl;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        s_a, s_na, s_b;
    logic [7:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [31:0] mon_dreg;
    logic        mon_ready, mon_error;

    always #5 clk = ~clk;

    nios2_debug_ocimem_ctrl #(.ADDR_W(8), .STARVE_LIMIT(LIMIT)) dut (
        .i_clk                     (clk),
        .i_reset_n                 (reset_n),
        .i_jdo                     (jdo),
        .i_take_action_ocimem_a    (s_a),
        .i_take_no_action_ocimem_a (s_na),
        .i_take_action_ocimem_b    (s_b),
        .i_avs_address             (avs_address),
        .i_avs_read                (avs_read),
        .i_avs_write               (avs_write),
        .i_avs_writedata           (avs_writedata),
        .i_avs_byteenable          (avs_byteenable),
        .o_avs_readdata            (avs_readdata),
        .o_avs_waitrequest         (avs_waitrequest),
        .o_mon_dreg                (mon_dreg),
        .o_monitor_ready           (mon_ready),
        .o_monitor_error           (mon_error)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: phase 0 = idle, 1 = read waiting for RAM, 2 = write waiting,
    // 3 = read data arriving. m_lost counts consecutive RAM slots lost to the CPU.
    logic [31:0] m_mem [256];
    logic [31:0] m_mon_d, m_rdata, m_cap;
    logic [7:0]  m_mon_a;
    logic        m_ready, m_err;
    int          m_ph, m_lost;
    logic        g_wait_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mon_d = '0; m_rdata = '0; m_cap = '0; m_mon_a = '0;
        m_ready = 1'b0; m_err = 1'b0; m_ph = 0; m_lost = 0;
    endtask

    function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd);
        logic [37:0] j = '0;
        j[17 +: 8] = addr;
        j[34] = rd;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] wd);
        logic [37:0] j = '0;
        j[34:3] = wd;
        return j;
    endfunction

    // One clock cycle: drive at the falling edge, check, advance model, wait for next fall.
    task automatic cyc(input logic a, input logic na, input logic b, input logic [37:0] j,
                       input logic rd, input logic wr, input logic [7:0] ad,
                       input logic [31:0] wd, input logic [3:0] be);
        logic exp_wait, go, acc;
        int old_ph;
        logic [31:0] n_rdata;
        s_a = a; s_na = na; s_b = b; jdo = j;
        avs_read = rd; avs_write = wr; avs_address = ad;
        avs_writedata = wd; avs_byteenable = be;
        #1;
        acc = rd | wr;
        exp_wait = (m_ph == 1 || m_ph == 2) && acc && (m_lost == LIMIT);
        g_wait_seen = avs_waitrequest;
        chk("waitrequest", {31'd0, avs_waitrequest}, {31'd0, exp_wait});
        chk("avs_readdata", avs_readdata, m_rdata);
        chk("MonDReg", mon_dreg, m_mon_d);
        chk("monitor_ready", {31'd0, mon_ready}, {31'd0, m_ready});
        chk("monitor_error", {31'd0, mon_error}, {31'd0, m_err});

        go = (m_ph == 1 || m_ph == 2) && (!acc || m_lost == LIMIT);
        n_rdata = m_rdata;
        if (rd && !wr && !exp_wait) n_rdata = m_mem[ad];
        old_ph = m_ph;
        case (old_ph)
            0: begin
                if (a) begin
                    m_mon_a = j[24:17];
                    if (j[34]) begin m_ph = 1; m_ready = 1'b0; end
                    else m_ready = 1'b1;
                end else if (na) begin
                    m_mon_a = m_mon_a + 8'd1; m_ph = 1; m_ready = 1'b0;
                end else if (b) begin
                    m_mon_d = j[34:3]; m_ph = 2; m_ready = 1'b0;
                end
            end
            1: if (go) begin m_cap = m_mem[m_mon_a]; m_ph = 3; end
            2: if (go) begin
                m_mem[m_mon_a] = m_mon_d; m_mon_a = m_mon_a + 8'd1;
                m_ready = 1'b1; m_ph = 0;
            end
            default: begin m_mon_d = m_cap; m_ready = 1'b1; m_ph = 0; end
        endcase
        if (old_ph != 0 && (a || na || b)) m_err = 1'b1;
        if ((old_ph == 1 || old_ph == 2) && !go && acc) m_lost = (m_lost < LIMIT) ? m_lost + 1 : LIMIT;
        else m_lost = 0;
        if (wr && !exp_wait)
            for (int k = 0; k < 4; k++) if (be[k]) m_mem[ad][8*k +: 8] = wd[8*k +: 8];
        m_rdata = n_rdata;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, '0, 0, 0, 8'h00, '0, 4'h0);
    endtask

    task automatic cpu_wr(input logic [7:0] ad, input logic [31:0] wd);
        cyc(0, 0, 0, '0, 0, 1, ad, wd, 4'hF);
    endtask

    task automatic cpu_rd(input logic [7:0] ad);
        cyc(0, 0, 0, '0, 1, 0, ad, '0, 4'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_MonDReg"}, mon_dreg, 32'h0);
        chk({tag, "_ready"}, {31'd0, mon_ready}, 32'd0);
        chk({tag, "_error"}, {31'd0, mon_error}, 32'd0);
        chk({tag, "_readdata"}, avs_readdata, 32'h0);
        chk({tag, "_wait"}, {31'd0, avs_waitrequest}, 32'd0);
    endtask

    task automatic scen2(input string tag);
        cyc(1, 0, 0, jdo_a(8'h10, 1'b1), 0, 0, 8'h00, '0, 4'h0);
        idle(2);
        chk({tag, "_rd_data"}, mon_dreg, 32'hDEADBEEF);
        chk({tag, "_rd_ready"}, {31'd0, mon_ready}, 32'd1);
        cyc(0, 1, 0, '0, 0, 0, 8'h00, '0, 4'h0);
        idle(2);
        chk({tag, "_next_data"}, mon_dreg, 32'h11111111);
    endtask

    initial begin
        logic [63:0] rnd;
        int r;
        reset_n = 1'b0;
        s_a = 0; s_na = 0; s_b = 0; jdo = '0;
        avs_read = 0; avs_write = 0; avs_address = '0; avs_writedata = '0; avs_byteenable = '0;
        model_reset();
        for (int k = 0; k < 256; k++) m_mem[k] = '0;
        @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        for (int k = 0; k < 256; k++) cpu_wr(k[7:0], $urandom);
        cpu_wr(8'h00, 32'h0A0A0A0A);
        cpu_wr(8'h11, 32'h11111111);
        cpu_wr(8'h20, 32'h20202020);
        cpu_wr(8'h30, 32'h30303030);
        idle(1);

        // 1: set address, write DEADBEEF
        cyc(1, 0, 0, jdo_a(8'h10, 1'b0), 0, 0, 8'h00, '0, 4'h0);
        chk("s1_a_ready", {31'd0, mon_ready}, 32'd1);
        cyc(0, 0, 1, jdo_b(32'hDEADBEEF), 0, 0, 8'h00, '0, 4'h0);
        idle(1);
        chk("s1_wr_ready", {31'd0, mon_ready}, 32'd1);
        cpu_rd(8'h10);
        chk("s1_ram", avs_readdata, 32'hDEADBEEF);

        // 2: read back, then auto-increment read
        scen2("s2");

        // 3: address wrap 0xFF -> 0x00
        cyc(1, 0, 0, jdo_a(8'hFF, 1'b0), 0, 0, 8'h00, '0, 4'h0);
        cyc(0, 1, 0, '0, 0, 0, 8'h00, '0, 4'h0);
        idle(2);
        chk("s3_wrap", mon_dreg, 32'h0A0A0A0A);

        // 4: CPU reads every cycle while the JTAG read is pending
        cyc(1, 0, 0, jdo_a(8'h20, 1'b1), 0, 0, 8'h00, '0, 4'h0);
        for (int k = 1; k <= 6; k++) begin
            cpu_rd(8'h30);
            chk("s4_wait_pos", {31'd0, g_wait_seen}, (k == 5) ? 32'd1 : 32'd0);
        end
        chk("s4_jtag", mon_dreg, 32'h20202020);
        chk("s4_cpu", avs_readdata, 32'h30303030);
        idle(1);

        // 5: overrun while a write is pending
        cyc(1, 0, 0, jdo_a(8'h40, 1'b0), 0, 0, 8'h00, '0, 4'h0);
        cyc(0, 0, 1, jdo_b(32'h55AA55AA), 0, 0, 8'h00, '0, 4'h0);
        cyc(0, 0, 1, jdo_b(32'h12345678), 0, 0, 8'h00, '0, 4'h0);
        idle(3);
        chk("s5_error", {31'd0, mon_error}, 32'd1);
        cpu_rd(8'h40);
        chk("s5_first_wr", avs_readdata, 32'h55AA55AA);

        // 6: reset while capturing a read
        cyc(1, 0, 0, jdo_a(8'h10, 1'b1), 0, 0, 8'h00, '0, 4'h0);
        idle(1);
        reset_n = 1'b0;
        s_a = 0; s_na = 0; s_b = 0; avs_read = 0; avs_write = 0;
        #1;
        check_reset_outputs("s6_reset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);
        scen2("s6");

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            rnd = {$urandom, $urandom};
            r = $urandom_range(0, 3);
            cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                rnd[37:0], (r == 1 || r == 3), (r == 2), 8'($urandom), $urandom, 4'($urandom));
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
